// File: rtl/pid_pkg.sv
// Shared state encoding and width helper for the sequential PID controller.
package pid_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ERR  = 3'd1,
        S_MP   = 3'd2,
        S_MI   = 3'd3,
        S_MD   = 3'd4,
        S_OUT  = 3'd5
    } pid_state_t;

    // Wide enough that kp*e + ki*integ + kd*d can never overflow.
    function automatic int acc_width(input int w, input int int_w);
        return w + int_w + 2;
    endfunction

endpackage

// File: rtl/pid_sat.sv
// Arithmetic right shift and signed saturation of the PID accumulator to W bits.
module pid_sat #(
    parameter int W     = 16,
    parameter int ACC_W = 42,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [W-1:0]     sat
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc >>> SHIFT;

    always_comb begin
        sat = shifted[W-1:0];
        if (shifted > MAX_V)
            sat = {1'b0, {(W-1){1'b1}}};
        else if (shifted < MIN_V)
            sat = {1'b1, {(W-1){1'b0}}};
    end

endmodule

// File: rtl/pid_seq_ctrl.sv
// Signed PID controller sharing one multiplier across P/I/D terms via a small FSM.
// Define PID_DERIV_EN to include the derivative term (MD state, e_prev, kd).
module pid_seq_ctrl
    import pid_pkg::*;
#(
    parameter int W       = 16,
    parameter int INT_W   = W + 8,
    parameter int INT_LIM = 2 ** (W + 4),
    parameter int SHIFT   = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_clr,
    input  logic signed [W-1:0] sp,
    input  logic signed [W-1:0] pv,
    input  logic signed [W-1:0] kp,
    input  logic signed [W-1:0] ki,
    input  logic signed [W-1:0] kd,
    output logic signed [W-1:0] o_un,
    output logic                o_valid,
    output logic                o_busy
);

    localparam int ACC_W = acc_width(W, INT_W);
    localparam logic signed [INT_W:0] LIM_P = (INT_W+1)'(INT_LIM);
    localparam logic signed [INT_W:0] LIM_N = -LIM_P;

    pid_state_t state;

    logic signed [W-1:0]     sp_r, pv_r, kp_r, ki_r;
    logic signed [W:0]       e_r;
    logic signed [INT_W-1:0] integ;
    logic signed [ACC_W-1:0] acc;

    logic signed [W:0]       e_new;
    logic signed [INT_W:0]   integ_sum;
    logic signed [INT_W-1:0] integ_nxt;
    logic signed [ACC_W-1:0] mul_a, mul_b, prod;
    logic signed [W-1:0]     sat_un;

`ifdef PID_DERIV_EN
    logic signed [W-1:0] kd_r;
    logic signed [W:0]   e_prev;
    logic signed [W+1:0] d_r, d_new;

    assign d_new = (W+2)'(e_new) - (W+2)'(e_prev);
`else
    logic unused_kd;

    assign unused_kd = ^kd;
`endif

    assign e_new     = (W+1)'(sp_r) - (W+1)'(pv_r);
    assign integ_sum = (INT_W+1)'(integ) + (INT_W+1)'(e_new);

    always_comb begin
        integ_nxt = INT_W'(integ_sum);
        if (integ_sum > LIM_P)
            integ_nxt = INT_W'(LIM_P);
        else if (integ_sum < LIM_N)
            integ_nxt = INT_W'(LIM_N);
    end

    // Single shared multiplier; operands steered by the current phase.
    always_comb begin
        mul_a = ACC_W'(kp_r);
        mul_b = ACC_W'(e_r);
        case (state)
            S_MI: begin
                mul_a = ACC_W'(ki_r);
                mul_b = ACC_W'(integ);
            end
`ifdef PID_DERIV_EN
            S_MD: begin
                mul_a = ACC_W'(kd_r);
                mul_b = ACC_W'(d_r);
            end
`endif
            default: ;
        endcase
    end

    assign prod = mul_a * mul_b;

    pid_sat #(.W(W), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_sat (
        .acc (acc),
        .sat (sat_un)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= S_IDLE;
            sp_r    <= '0;
            pv_r    <= '0;
            kp_r    <= '0;
            ki_r    <= '0;
            e_r     <= '0;
            integ   <= '0;
            acc     <= '0;
            o_un    <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
`ifdef PID_DERIV_EN
            kd_r    <= '0;
            e_prev  <= '0;
            d_r     <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Clear lands before ERR, so a same-cycle start sees a fresh integrator.
                    if (i_clr) begin
                        integ  <= '0;
`ifdef PID_DERIV_EN
                        e_prev <= '0;
`endif
                    end
                    if (i_start) begin
                        sp_r   <= sp;
                        pv_r   <= pv;
                        kp_r   <= kp;
                        ki_r   <= ki;
`ifdef PID_DERIV_EN
                        kd_r   <= kd;
`endif
                        o_busy <= 1'b1;
                        state  <= S_ERR;
                    end
                end
                S_ERR: begin
                    e_r    <= e_new;
                    integ  <= integ_nxt;
`ifdef PID_DERIV_EN
                    d_r    <= d_new;
                    e_prev <= e_new;
`endif
                    state  <= S_MP;
                end
                S_MP: begin
                    acc   <= prod;
                    state <= S_MI;
                end
                S_MI: begin
                    acc   <= acc + prod;
`ifdef PID_DERIV_EN
                    state <= S_MD;
`else
                    state <= S_OUT;
`endif
                end
`ifdef PID_DERIV_EN
                S_MD: begin
                    acc   <= acc + prod;
                    state <= S_OUT;
                end
`endif
                S_OUT: begin
                    o_un    <= sat_un;
                    o_valid <= 1'b1;
                    o_busy  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_seq_ctrl.sv
// Self-checking bench for pid_seq_ctrl: vector table plus handshake/reset sequences.
module tb_pid_seq_ctrl;

    localparam int W   = 16;
    localparam int LIM = 100;
`ifdef PID_DERIV_EN
    localparam bit DERIV = 1'b1;
    localparam int LAT   = 5;
`else
    localparam bit DERIV = 1'b0;
    localparam int LAT   = 4;
`endif
    localparam int PERIOD = LAT + 1;

    logic i_clk = 1'b0, i_rst = 1'b0, i_start = 1'b0, i_clr = 1'b0;
    logic signed [W-1:0] sp = '0, pv = '0, kp = '0, ki = '0, kd = '0;
    logic signed [W-1:0] o_un;
    logic o_valid, o_busy;

    pid_seq_ctrl #(.W(W), .INT_LIM(LIM)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_clr   (i_clr),
        .sp      (sp),
        .pv      (pv),
        .kp      (kp),
        .ki      (ki),
        .kd      (kd),
        .o_un    (o_un),
        .o_valid (o_valid),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct { int un; int at; string name; } exp_t;
    exp_t sb[$];

    typedef struct { int s, p, g_p, g_i, g_d; bit clr; int exp_d, exp_nd; } vec_t;
    vec_t tab[10];

    longint m_integ = 0, m_eprev = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every o_valid must match the oldest pending request.
    always @(negedge i_clk) begin
        if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check({x.name, "_o_un"}, longint'(o_un), x.un);
                check({x.name, "_latency"}, cyc, x.at);
            end
        end
    end

    task automatic model_step(input longint s, p, g_p, g_i, g_d, input bit clr, output int res);
        longint e, d, a;
        if (clr) begin
            m_integ = 0;
            m_eprev = 0;
        end
        e = s - p;
        m_integ = m_integ + e;
        if (m_integ > LIM) m_integ = LIM;
        else if (m_integ < -LIM) m_integ = -LIM;
        d = e - m_eprev;
        m_eprev = e;
        a = g_p * e + g_i * m_integ + (DERIV ? g_d * d : 64'sd0);
        if (a > 32767) a = 32767;
        else if (a < -32768) a = -32768;
        res = int'(a);
    endtask

    task automatic drive(input int s, p, g_p, g_i, g_d, input bit clr);
        sp = 16'(s); pv = 16'(p); kp = 16'(g_p); ki = 16'(g_i); kd = 16'(g_d);
        i_clr = clr;
        i_start = 1'b1;
    endtask

    task automatic push_exp(input string name, input int un);
        exp_t x;
        x.un = un; x.at = cyc + 1 + LAT; x.name = name;
        sb.push_back(x);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || o_busy) && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        if (sb.size() != 0 || o_busy) begin
            check({name, "_timeout"}, 0, 1);
            sb.delete();
        end
    endtask

    // Caller sits at a negedge; acceptance happens on the next rising edge.
    task automatic do_req(input string name, input int s, p, g_p, g_i, g_d, input bit clr,
                          input bit use_tab, input int tab_exp);
        int res;
        drive(s, p, g_p, g_i, g_d, clr);
        model_step(s, p, g_p, g_i, g_d, clr, res);
        push_exp(name, use_tab ? tab_exp : res);
        @(negedge i_clk);
        i_start = 1'b0;
        i_clr   = 1'b0;
        check({name, "_busy"}, o_busy, 1);
        wait_idle(name);
    endtask

    initial begin
        int res;
        tab[0] = '{450, 300, 5, 0, 0, 1'b0, 750, 750};
        tab[1] = '{450, 150, 5, 0, 0, 1'b0, 1500, 1500};
        tab[2] = '{32767, -32768, 2, 0, 0, 1'b0, 32767, 32767};
        tab[3] = '{-32768, 32767, 2, 0, 0, 1'b0, -32768, -32768};
        tab[4] = '{60, 0, 0, 1, 0, 1'b1, 60, 60};
        tab[5] = '{60, 0, 0, 1, 0, 1'b0, 100, 100};
        tab[6] = '{60, 0, 0, 1, 0, 1'b1, 60, 60};
        tab[7] = '{10, 0, 0, 0, 2, 1'b1, 20, 0};
        tab[8] = '{30, 0, 0, 0, 2, 1'b0, 40, 0};
        tab[9] = '{-50, 20, 3, 2, 1, 1'b0, -370, -270};

        repeat (3) @(negedge i_clk);
        check("rst_o_un", longint'(o_un), 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_busy", o_busy, 0);
        i_rst = 1'b1;
        @(negedge i_clk);

        foreach (tab[i])
            do_req($sformatf("vec%0d", i), tab[i].s, tab[i].p, tab[i].g_p, tab[i].g_i,
                   tab[i].g_d, tab[i].clr, 1'b1, DERIV ? tab[i].exp_d : tab[i].exp_nd);

        // i_start held high: one acceptance per PERIOD cycles, no more.
        drive(100, 0, 1, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            model_step(100, 0, 1, 0, 0, 1'b0, res);
            push_exp($sformatf("held%0d", k), res);
            if (k < 2) repeat (PERIOD) @(negedge i_clk);
            else @(negedge i_clk);
        end
        i_start = 1'b0;
        wait_idle("held");
        check("held_o_un_hold", longint'(o_un), 100);

        // Mid-run start pulse and sp change must not disturb the in-flight request.
        drive(200, 0, 1, 0, 0, 1'b0);
        model_step(200, 0, 1, 0, 0, 1'b0, res);
        push_exp("midpulse", res);
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        sp = 16'sd999;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_idle("midpulse");

        // Reset mid-computation, after the integrator has been loaded.
        do_req("preload", 40, 0, 0, 1, 0, 1'b1, 1'b0, 0);
        drive(30, 0, 0, 1, 0, 1'b0);
        @(negedge i_clk);
        i_start = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        #1;
        check("midrst_o_busy", o_busy, 0);
        check("midrst_o_un", longint'(o_un), 0);
        check("midrst_o_valid", o_valid, 0);
        m_integ = 0;
        m_eprev = 0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        repeat (PERIOD + 2) @(negedge i_clk);
        check("midrst_no_busy", o_busy, 0);
        do_req("post_rst", 30, 0, 0, 1, 0, 1'b0, 1'b0, 0);

        repeat (3) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
